// File: rtl/sigdel_pkg.sv
// Shared types and constants for the first-order sigma-delta DAC.
// Imported by the modulator core and the sample-pacing top level.
package sigdel_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sigdel_state_t;

  localparam int UNDERRUN_W = 16;

  // Offset-binary zero point for a sample of the given width.
  function automatic logic [31:0] midscale(input int unsigned bitlen);
    midscale = 32'd1 << (bitlen - 32'd1);
  endfunction

endpackage

// File: rtl/sigdel_mod1.sv
// First-order sigma-delta modulator: the carry-out of the phase accumulator
// becomes the registered pulse-density bit.
module sigdel_mod1 #(
  parameter int BITLEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITLEN-1:0] hold,
  output logic              dac_out
);

  logic [BITLEN-1:0] acc_q;
  logic [BITLEN-1:0] acc_d;
  logic              dac_q;
  logic              dac_d;
  logic [BITLEN:0]   sum_s;

  // Accumulate the held sample; overflow is the output pulse.
  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, hold};
    acc_d = sum_s[BITLEN-1:0];
    dac_d = sum_s[BITLEN];
  end

  // Accumulator and output bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dac_q <= dac_d;
    end
  end

  assign dac_out = dac_q;

endmodule

// File: rtl/sigdel_dac.sv
// Sigma-delta DAC top: paces sample intake to one per OSR clocks, holds the
// last sample on underrun and counts missed slots.
module sigdel_dac
  import sigdel_pkg::*;
#(
  parameter int BITLEN = 16,
  parameter int OSR    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITLEN-1:0]     sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  dac_out,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int                PW         = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0]     PHASE_LAST = PW'(OSR - 1);
  localparam logic [PW-1:0]     PHASE_ONE  = PW'(1);
  localparam logic [BITLEN-1:0] MID        = BITLEN'(midscale(BITLEN));
  localparam logic [UNDERRUN_W-1:0] UND_ONE = UNDERRUN_W'(1);
  localparam logic [UNDERRUN_W-1:0] UND_MAX = {UNDERRUN_W{1'b1}};

  sigdel_state_t         state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [BITLEN-1:0]     hold_q, hold_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
  logic                  ready_q, ready_d;

  // Sample pacing FSM, hold register update and underrun accounting.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    case (state_q)
      IDLE: begin
        if (sample_valid && ready_q) begin
          hold_d  = sample_in;
          phase_d = '0;
          state_d = RUN;
        end else begin
          phase_d = '0;
        end
      end
      RUN: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (sample_valid) begin
            hold_d = sample_in;
          end else if (underrun_q != UND_MAX) begin
            underrun_d = underrun_q + UND_ONE;
          end else begin
            underrun_d = underrun_q;
          end
        end else begin
          phase_d = phase_q + PHASE_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    // Ready is precomputed from next state so the port comes straight off a flop.
    ready_d = (state_d == IDLE) || (phase_d == PHASE_LAST);
  end

  // Control and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      hold_q     <= MID;
      underrun_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
    end
  end

  sigdel_mod1 #(.BITLEN(BITLEN)) u_mod1 (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold_q),
    .dac_out (dac_out)
  );

  assign sample_ready = ready_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_sigdel_dac.sv
// Directed self-checking bench for sigdel_dac at BITLEN=16, OSR=64.
module tb_sigdel_dac;

  localparam int BITLEN = 16;
  localparam int OSR    = 64;

  logic        clk;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        dac_out;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] sine_tbl [0:15] = '{
    16'h8000, 16'hAADC, 16'hCF32, 16'hE77A, 16'hF000, 16'hE77A, 16'hCF32, 16'hAADC,
    16'h8000, 16'h5524, 16'h30CE, 16'h1886, 16'h1000, 16'h1886, 16'h30CE, 16'h5524
  };

  sigdel_dac #(.BITLEN(BITLEN), .OSR(OSR)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_out      (dac_out),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!sample_ready && n < OSR + 4) begin
      tick();
      n++;
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready: ready never rose within %0d cycles", name, OSR + 4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b0; sample_in = 16'h0000;
    tick(); tick();
    rst = 1'b0;
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", sample_ready); end
    checks++; if (dac_out !== 1'b0) begin errors++; $display("FAIL reset_dac: got %0b expected 0", dac_out); end
    checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL reset_underrun: got %h expected 0000", underrun_cnt); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dac_out !== 1'(i % 2)) begin errors++; $display("FAIL idle_toggle[%0d]: got %0b expected %0b", i, dac_out, 1'(i % 2)); end
    end
    checks++; if (sample_ready !== 1'b1 || underrun_cnt !== 16'h0000) begin
      errors++; $display("FAIL idle_hold: ready %0b underrun %h expected 1 / 0000", sample_ready, underrun_cnt);
    end
  endtask

  task automatic test_zero();
    sample_in = 16'h0000; sample_valid = 1'b1;
    tick();
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL zero_ready0: got %0b expected 0", sample_ready); end
    for (int k = 1; k <= 192; k++) begin
      tick();
      if (k >= 2) begin
        checks++; if (dac_out !== 1'b0) begin errors++; $display("FAIL zero_dac[%0d]: got %0b expected 0", k, dac_out); end
      end
      checks++;
      if (sample_ready !== ((k % 64) == 63)) begin
        errors++; $display("FAIL zero_ready_cadence[%0d]: got %0b expected %0b", k, sample_ready, (k % 64) == 63);
      end
    end
  endtask

  task automatic test_c000();
    int ones;
    sample_in = 16'hC000;
    wait_ready("c000");
    tick();
    ones = 0;
    for (int k = 0; k < 1024; k++) begin
      tick();
      ones += int'(dac_out);
    end
    checks++; if (ones < 767 || ones > 769) begin errors++; $display("FAIL c000_density: got %0d ones expected 768+-1", ones); end
    checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL c000_underrun: got %h expected 0000", underrun_cnt); end
  endtask

  task automatic test_underrun();
    int ones;
    sample_in = 16'h4000;
    wait_ready("underrun");
    tick();
    sample_valid = 1'b0;
    ones = 0;
    for (int k = 1; k <= 192; k++) begin
      tick();
      ones += int'(dac_out);
      if ((k % 64) == 0) begin
        checks++;
        if (underrun_cnt !== 16'(k / 64)) begin errors++; $display("FAIL underrun_cnt[%0d]: got %h expected %h", k, underrun_cnt, 16'(k / 64)); end
      end
      if ((k % 64) == 63) begin
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL underrun_ready[%0d]: got %0b expected 1", k, sample_ready); end
      end
    end
    checks++; if (ones < 47 || ones > 49) begin errors++; $display("FAIL underrun_density: got %0d ones expected 48+-1", ones); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt [0:2];
    exp_cnt[0] = 16'hFFFE; exp_cnt[1] = 16'hFFFF; exp_cnt[2] = 16'hFFFF;
    force dut.underrun_q = 16'hFFFD;
    #1;
    release dut.underrun_q;
    checks++; if (underrun_cnt !== 16'hFFFD) begin errors++; $display("FAIL sat_preload: got %h expected fffd", underrun_cnt); end
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 64; k++) tick();
      checks++;
      if (underrun_cnt !== exp_cnt[s]) begin errors++; $display("FAIL sat_cnt[%0d]: got %h expected %h", s, underrun_cnt, exp_cnt[s]); end
    end
  endtask

  task automatic test_reset_mid();
    sample_in = 16'h2000; sample_valid = 1'b1;
    wait_ready("reset_mid");
    tick();
    for (int k = 0; k < 20; k++) tick();
    sample_in = 16'hFFFF; rst = 1'b1;
    tick();
    rst = 1'b0; sample_valid = 1'b0;
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0b expected 1", sample_ready); end
    checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL rmid_underrun: got %h expected 0000", underrun_cnt); end
    checks++; if (dac_out !== 1'b0) begin errors++; $display("FAIL rmid_dac: got %0b expected 0", dac_out); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dac_out !== 1'(i % 2)) begin errors++; $display("FAIL rmid_toggle[%0d]: got %0b expected %0b", i, dac_out, 1'(i % 2)); end
    end
  endtask

  task automatic test_sine();
    int ones;
    int diff;
    sample_in = sine_tbl[0]; sample_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      ones = 0;
      for (int j = 0; j < 64; j++) begin
        if (j == 63) begin
          checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL sine_ready[%0d]: got %0b expected 1", i, sample_ready); end
          sample_in = sine_tbl[(i + 1) % 16];
        end
        tick();
        ones += int'(dac_out);
      end
      diff = ones * 1024 - int'(sine_tbl[i]);
      checks++;
      if (diff > 1024 || diff < -1024) begin
        errors++; $display("FAIL sine_track[%0d]: got %0d ones (x1024=%0d) expected near %0d", i, ones, ones * 1024, sine_tbl[i]);
      end
    end
    checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL sine_underrun: got %h expected 0000", underrun_cnt); end
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_in = 16'h0000;
    test_reset();
    test_zero();
    test_c000();
    test_underrun();
    test_saturation();
    test_reset_mid();
    test_sine();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigdel_dac.md
# sigdel_dac

First-order sigma-delta DAC core that consumes the unsigned PCM sample stream produced by the sine generator and emits a 1-bit pulse-density stream for the FPGA output pin. It sits downstream of the sample source and pulls one sample every OSR clocks through a valid/ready handshake. It holds the last sample on underrun and counts each underrun for debug.

## Interface
- BITLEN, 16: sample width; unsigned offset-binary, midscale = 2^(BITLEN-1).
- OSR, 64: oversampling ratio, the number of clocks per consumed sample; legal range ≥ 2.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  BITLEN  PCM sample; sampled only on a handshake.
- sample_valid  in  1  source has a sample on sample_in.
- sample_ready  out  1  core accepts sample_in this cycle; driven from registered state only, never from sample_valid.
- dac_out  out  1  registered pulse-density output.
- underrun_cnt  out  16  saturating count of missed sample slots.

## Operation
- States: IDLE, RUN.
- IDLE (after reset):
  - sample_ready = 1.
  - hold = midscale, so dac_out toggles 0,1,0,1….
  - On sample_valid & sample_ready: hold <= sample_in, phase <= 0, go to RUN.
- RUN:
  - phase counts 0..OSR-1, then wraps to 0.
  - sample_ready = 1 only when phase == OSR-1.
  - At phase OSR-1 with sample_valid = 1: hold <= sample_in.
  - At phase OSR-1 with sample_valid = 0 (underrun): hold is unchanged and underrun_cnt <= underrun_cnt+1, saturating at 0xFFFF. The modulator keeps running.
- Modulator (every cycle, in both states):
  - sum = {1'b0,acc} + {1'b0,hold}, width BITLEN+1.
  - acc <= sum[BITLEN-1:0].
  - dac_out <= sum[BITLEN].
  - Long-run density of ones = hold / 2^BITLEN.
- RUN never returns to IDLE; only rst leaves RUN.
- rst mid-operation: every register returns to its reset value on that edge. A sample presented in the reset cycle is not accepted.

## Timing
- Reset values:
  - dac_out = 0, acc = 0, hold = 2^(BITLEN-1), phase = 0, underrun_cnt = 0, state = IDLE.
  - sample_ready = 1 in the first cycle after reset is released, because it is decoded from IDLE.
- Latency: a sample accepted at edge t drives the adder from cycle t+1; its first effect on dac_out is registered at edge t+2.
- Acceptance cadence in RUN: exactly one ready cycle per OSR clocks. The first ready cycle comes OSR-1 cycles after the IDLE→RUN edge, so the first RUN sample is held for exactly OSR clocks.
- Handshake: the transfer occurs only in a cycle where valid & ready are both high. The source may hold valid high continuously. The core ignores sample_in while ready = 0.
- Simultaneous events:
  - The underrun increment and the hold update are mutually exclusive by construction.
  - The accumulator carry-out and the hold update in the same cycle are both legal; the new hold affects only the following cycle's sum.
- No combinational path from any input to any output.

## Structure
- Package sigdel_pkg holds:
  - state enum sigdel_state_t {IDLE, RUN}.
  - localparam function midscale(BITLEN).
  - UNDERRUN_W = 16.
- Sub-module sigdel_mod1 holds the accumulator, adder and dac_out register: inputs clk, rst, hold[BITLEN-1:0]; output dac_out.
- Top-level sigdel_dac holds the FSM, phase counter ($clog2(OSR) bits), hold register and underrun counter.

## Test plan
- Reset, then no valid: sample_ready = 1; dac_out over 8 cycles = 0,1,0,1,0,1,0,1; underrun_cnt stays 0.
- Handshake sample 0x0000, then valid held high with 0x0000: after 2 cycles dac_out = 0 continuously; sample_ready pulses exactly every 64 clocks.
- Constant 0xC000 for 16 sample periods (1024 clocks): dac_out ones count = 768 ±1; no underruns.
- Enter RUN, then deassert valid for 3 ready slots: underrun_cnt = 3; the held sample persists, so the ones density is unchanged. Force 70000 missed slots: underrun_cnt saturates at 0xFFFF.
- Full sine ROM stream at OSR = 64, low-pass filtered by a moving average over 64 dac_out bits: tracks the input sample within ±1 LSB × 2^(16-6).
- Assert rst in the middle of a RUN period with valid high: the next cycle shows IDLE, hold = 0x8000, underrun_cnt = 0, dac_out = 0, sample_ready = 1.
